// File: rtl/decoder_arb_pkg.sv
// Shared types and helpers for the decoder arbiter: FSM state encoding,
// default decoder widths and a one-hot helper.
package decoder_arb_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} arb_state_t;

  localparam int DEC_IN_W  = 7;
  localparam int DEC_OUT_W = 8;
  localparam int MAX_REQ   = 8;

  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_REQ-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      v[i] = (i == idx) && (i < n);
    end
    return v;
  endfunction

endpackage

// File: rtl/decoder_arbiter_rr_pick.sv
// Round-robin pick: lowest active request at or above ptr, wrapping to the
// bottom of the vector when nothing above ptr is requesting.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     any
);

  localparam int PW = $clog2(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] masked;

  // The upper copy of req supplies the wrapped-around candidates, so the
  // lowest set bit of the masked double vector is the round-robin winner.
  always_comb begin
    dbl     = {req, req};
    masked  = dbl & ({(2*N_REQ){1'b1}} << ptr);
    any     = |req;
    gnt_idx = '0;
    for (int unsigned i = 2*N_REQ; i > 0; i--) begin
      if (masked[i-1]) gnt_idx = PW'((i - 1) % N_REQ);
    end
  end

endmodule

// File: rtl/decoder_arbiter.sv
// Shares one combinational decoder among N_REQ requesters: round-robin
// grant, hold the code for SETTLE cycles, capture and return the result.
module decoder_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DEC_IN_W,
  parameter int OUT_W  = DEC_OUT_W,
  parameter int SETTLE = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [OUT_W-1:0]        rsp_data,
  output logic [DATA_W-1:0]       dec_in,
  input  logic [OUT_W-1:0]        dec_out
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  arb_state_t        state, state_n;
  logic [PW-1:0]     ptr, gnt, pick;
  logic              any;
  logic              accept;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] pick_code;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt_idx (pick),
    .any     (any)
  );

  always_comb begin
    pick_code = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick == PW'(i)) pick_code = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (any && !reset) begin
          accept  = 1'b1;
          state_n = DRIVE;
        end
      end
      DRIVE:   if (cnt == '0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready = accept ? N_REQ'(onehot(32'(pick), N_REQ)) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      cnt       <= '0;
      dec_in    <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (accept) begin
            dec_in <= pick_code;
            gnt    <= pick;
            cnt    <= CW'(SETTLE - 1);
            ptr    <= (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data  <= dec_out;
            rsp_valid <= N_REQ'(onehot(32'(gnt), N_REQ));
          end
        end
        RESP:    rsp_valid <= '0;
        default: ;
      endcase
    end
  end

endmodule
